// File: rtl/si570_pkg.sv
// Purpose : Si570 register map, I2C command formats and the RFREQ/HS_DIV/N1 decode,
//           shared by the readback block and the programming FSM.
// Latency : n/a (constants, types and pure functions only).
// Backpressure: n/a.
package si570_pkg;

    localparam logic [6:0] SI570_ADDR = 7'h5d;
    localparam logic [6:0] MUX_ADDR   = 7'h74;
    localparam logic [7:0] MUX_CHAN   = 8'h01;
    localparam logic [7:0] REG_BASE   = 8'h07;
    localparam logic [3:0] OP_WR      = 4'h2;
    localparam logic [3:0] OP_RD      = 4'h4;

    // {valid, opcode, 7-bit address, r/w, register/data byte, 16-bit payload}
    typedef logic [36:0] i2c_cmd_t;

    // Raw frequency registers 7..12; element 0 holds reg 7.
    typedef logic [5:0][7:0] si570_regs_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_I2CSW,
        ST_RD,
        ST_COMMIT,
        ST_FAIL
    } rb_state_e;

    typedef struct packed {
        logic [2:0]  hs_div;
        logic [6:0]  n1;
        logic [37:0] rfreq;
    } si570_fields_t;

    // Selects the Si570 channel on the I2C mux.
    function automatic i2c_cmd_t si570_mux_cmd();
        return {1'b1, OP_WR, MUX_ADDR, 1'b0, MUX_CHAN, 16'h0000};
    endfunction

    // Single-byte read of one Si570 register.
    function automatic i2c_cmd_t si570_rd_cmd(input logic [7:0] reg_addr);
        return {1'b1, OP_RD, SI570_ADDR, 1'b1, reg_addr, 16'h0000};
    endfunction

    // N1 and RFREQ straddle register boundaries, so they are rebuilt from
    // adjacent bytes rather than taken from a single register.
    function automatic si570_fields_t si570_decode(input si570_regs_t regs);
        si570_fields_t f;
        f.hs_div = regs[0][7:5];
        f.n1     = {regs[0][4:0], regs[1][7:6]};
        f.rfreq  = {regs[1][5:0], regs[2], regs[3], regs[4], regs[5]};
        return f;
    endfunction

endpackage

// File: rtl/si570_readback.sv
// Purpose : Opens the I2C mux, reads Si570 regs 7..12 one byte at a time and commits
//           HS_DIV/N1/RFREQ atomically once all six bytes have arrived.
// Latency : i2cstart 3 cycles after start (engine idle); done 1 cycle after COMMIT/FAIL.
// Backpressure: each command holds until cnt>CNT and ~i2cbusy; start while busy is dropped.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start/busy/done/err request, in-progress, completion pulse, timeout flag
//   i2ccmd/i2cstart     command word and one-cycle strobe to the shared I2C engine
//   i2cbusy             engine busy
//   i2crdata/i2crvalid  read byte and its qualifying strobe
//   hs_div_now, n1_now, rfreq_now, newnow   decoded fields and per-register freshness
module si570_readback
    import si570_pkg::*;
#(
    parameter logic [15:0] CNT     = 16'd5,
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter logic [31:0] POLL    = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [36:0] i2ccmd,
    output logic        i2cstart,
    input  logic        i2cbusy,
    input  logic [7:0]  i2crdata,
    input  logic        i2crvalid,
    output logic [2:0]  hs_div_now,
    output logic [6:0]  n1_now,
    output logic [37:0] rfreq_now,
    output logic [5:0]  newnow
);

    rb_state_e     state_q;
    logic [15:0]   cnt_q;
    logic [15:0]   cnt_d;
    logic [31:0]   poll_q;
    logic [2:0]    idx_q;
    logic          got_q;
    logic          start_q;
    si570_regs_t   shadow_q;
    si570_fields_t fields_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          i2cstart_q;
    i2c_cmd_t      i2ccmd_q;
    logic [5:0]    newnow_q;
    logic          poll_hit;
    logic [2:0]    idx_nxt;

    // Saturating dwell counter; transitions below override it with zero.
    assign cnt_d    = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
    assign poll_hit = (POLL != 32'd0) && (poll_q == POLL - 32'd1);
    assign idx_nxt  = idx_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            poll_q     <= '0;
            idx_q      <= '0;
            got_q      <= 1'b0;
            start_q    <= 1'b0;
            shadow_q   <= '0;
            fields_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            i2cstart_q <= 1'b0;
            i2ccmd_q   <= '0;
            newnow_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            i2cstart_q <= 1'b0;
            cnt_q      <= (state_q == ST_IDLE) ? 16'd0 : cnt_d;
            poll_q     <= '0;

            // A request is only accepted while idle; busy rises with start_q so
            // a second request in the following cycles is dropped, not queued.
            start_q <= start & ~busy_q;
            if (start && !busy_q) begin
                busy_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    poll_q <= poll_q + 32'd1;
                    if (start_q || poll_hit) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                        poll_q  <= '0;
                    end
                end

                ST_START: begin
                    newnow_q <= '0;
                    err_q    <= 1'b0;
                    idx_q    <= '0;
                    got_q    <= 1'b0;
                    if (!i2cbusy) begin
                        state_q    <= ST_I2CSW;
                        cnt_q      <= '0;
                        i2cstart_q <= 1'b1;
                        i2ccmd_q   <= si570_mux_cmd();
                    end
                end

                ST_I2CSW: begin
                    if (cnt_q > CNT && !i2cbusy) begin
                        state_q    <= ST_RD;
                        cnt_q      <= '0;
                        i2cstart_q <= 1'b1;
                        i2ccmd_q   <= si570_rd_cmd(REG_BASE + {5'd0, idx_q});
                    end
                end

                ST_RD: begin
                    // Only the first byte of a visit counts; echoes are ignored.
                    if (i2crvalid && !got_q) begin
                        shadow_q[idx_q] <= i2crdata;
                        got_q           <= 1'b1;
                    end
                    if (got_q && cnt_q > CNT && !i2cbusy) begin
                        newnow_q[idx_q] <= 1'b1;
                        got_q           <= 1'b0;
                        cnt_q           <= '0;
                        if (idx_q == 3'd5) begin
                            state_q  <= ST_COMMIT;
                            i2ccmd_q <= '0;
                        end else begin
                            // Re-entering RD restarts the dwell count and re-strobes.
                            idx_q      <= idx_nxt;
                            i2cstart_q <= 1'b1;
                            i2ccmd_q   <= si570_rd_cmd(REG_BASE + {5'd0, idx_nxt});
                        end
                    end else if (!got_q && !i2crvalid && cnt_q >= TIMEOUT) begin
                        state_q  <= ST_FAIL;
                        cnt_q    <= '0;
                        i2ccmd_q <= '0;
                    end
                end

                ST_COMMIT: begin
                    fields_q <= si570_decode(shadow_q);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                end

                ST_FAIL: begin
                    // Fields keep the last good values; newnow keeps earned bits.
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign i2ccmd     = i2ccmd_q;
    assign i2cstart   = i2cstart_q;
    assign hs_div_now = fields_q.hs_div;
    assign n1_now     = fields_q.n1;
    assign rfreq_now  = fields_q.rfreq;
    assign newnow     = newnow_q;

endmodule

// File: tb/tb_si570_readback.sv
// Purpose : Directed bench for si570_readback with a cycle-stepped I2C engine model.
// Latency : checks start-to-i2cstart, command pacing and done timing.
// Backpressure: engine model holds i2cbusy for a programmable time after each command.
module tb_si570_readback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: on-demand readbacks, short timeout.
    logic        rst_n, start, i2cbusy, i2crvalid;
    logic [7:0]  i2crdata;
    logic        busy, done, err, i2cstart;
    logic [36:0] i2ccmd;
    logic [2:0]  hs_div_now;
    logic [6:0]  n1_now;
    logic [37:0] rfreq_now;
    logic [5:0]  newnow;

    // DUT B: polled readbacks.
    logic        rst_b_n, start_b, i2cbusy_b, i2crvalid_b;
    logic [7:0]  i2crdata_b;
    logic        busy_b, done_b, err_b, i2cstart_b;
    logic [36:0] i2ccmd_b;
    logic [2:0]  hs_b;
    logic [6:0]  n1_b;
    logic [37:0] rfreq_b;
    logic [5:0]  newnow_b;

    si570_readback #(.CNT(16'd5), .TIMEOUT(16'd100), .POLL(32'd0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .i2ccmd(i2ccmd), .i2cstart(i2cstart), .i2cbusy(i2cbusy), .i2crdata(i2crdata),
        .i2crvalid(i2crvalid), .hs_div_now(hs_div_now), .n1_now(n1_now),
        .rfreq_now(rfreq_now), .newnow(newnow)
    );

    si570_readback #(.CNT(16'd5), .TIMEOUT(16'd100), .POLL(32'd1000)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .start(start_b), .busy(busy_b), .done(done_b), .err(err_b),
        .i2ccmd(i2ccmd_b), .i2cstart(i2cstart_b), .i2cbusy(i2cbusy_b), .i2crdata(i2crdata_b),
        .i2crvalid(i2crvalid_b), .hs_div_now(hs_b), .n1_now(n1_b),
        .rfreq_now(rfreq_b), .newnow(newnow_b)
    );

    localparam logic [36:0] MUXC = {1'b1, 4'h2, 7'h74, 1'b0, 8'h01, 16'h0000};

    int nassert = 0;
    int nfail   = 0;
    int cyc     = 0;

    // Engine model A state / configuration
    logic [7:0] regs [6];
    int busy_dly, rsp_dly, drop_idx;
    int busy_wait, rsp_wait, pend_idx;
    bit pend, dup_pend, stray_en;
    int nstart_a, cmd_err, done_cnt, min_gap, last_start;

    // Engine model B / poll observation
    bit rsp_b, bdone_seen;
    int last_done_b, nb_gaps, gap1, gap2;
    logic [5:0] nn_sw_b, nn_done_b;

    function automatic logic [36:0] rdc(input int k);
        logic [7:0] r;
        r = 8'(7 + k);
        return {1'b1, 4'h4, 7'h5d, 1'b1, r, 16'h0000};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_regs(input logic [47:0] v);
        for (int k = 0; k < 6; k++) regs[k] = v[47-8*k -: 8];
    endtask

    task automatic clear_counts();
        nstart_a = 0; cmd_err = 0; done_cnt = 0; min_gap = 999999; last_start = -1;
    endtask

    task automatic reset_engine();
        busy_wait = 0; rsp_wait = 0; pend = 0; dup_pend = 0;
        i2cbusy = 0; i2crvalid = 0; i2crdata = 8'h00;
    endtask

    // One clock: advance to the falling edge, observe outputs, drive next inputs.
    task automatic tick();
        logic [36:0] expc;
        @(negedge clk);
        cyc++;
        // ---- engine A ----
        i2crvalid = 1'b0;
        i2crdata  = 8'h00;
        if (dup_pend) begin
            i2crvalid = 1'b1; i2crdata = 8'hA5; dup_pend = 0;
        end
        if (done) done_cnt++;
        if (i2cstart) begin
            expc = (nstart_a == 0) ? MUXC : rdc(nstart_a - 1);
            if (i2ccmd !== expc) cmd_err++;
            if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
            last_start = cyc;
            nstart_a++;
            busy_wait = busy_dly;
            if (i2ccmd[35:32] == 4'h4) begin
                pend = 1; pend_idx = int'(i2ccmd[23:16]) - 7; rsp_wait = rsp_dly;
            end else if (stray_en) begin
                i2crvalid = 1'b1; i2crdata = 8'h55;
            end
        end else begin
            if (busy_wait > 0) busy_wait--;
            if (pend) begin
                if (rsp_wait > 0) rsp_wait--;
                else begin
                    pend = 0;
                    if (pend_idx != drop_idx && pend_idx >= 0 && pend_idx < 6) begin
                        i2crvalid = 1'b1; i2crdata = regs[pend_idx]; dup_pend = 1;
                    end
                end
            end
        end
        i2cbusy = (busy_wait > 0);
        // ---- engine B: every read answered with 8'h11 one cycle later ----
        i2crvalid_b = 1'b0;
        i2crdata_b  = 8'h00;
        if (done_b) begin
            if (bdone_seen) nn_done_b = newnow_b;
            last_done_b = cyc; bdone_seen = 1;
        end
        if (i2cstart_b) begin
            if (i2ccmd_b[35:32] == 4'h4) rsp_b = 1;
            else if (bdone_seen) begin
                nb_gaps++;
                if (nb_gaps == 1) gap1 = cyc - last_done_b;
                if (nb_gaps == 2) gap2 = cyc - last_done_b;
                nn_sw_b = newnow_b;
            end
        end else if (rsp_b) begin
            i2crvalid_b = 1'b1; i2crdata_b = 8'h11; rsp_b = 0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        bit seen = 0;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (done) begin seen = 1; break; end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_starts(input int target, input int limit, input string tag);
        for (int n = 0; n < limit && nstart_a < target; n++) tick();
        check({tag, "_reached_cmd"}, 64'(nstart_a >= target), 64'd1);
    endtask

    task automatic check_fields(input string tag, input logic [2:0] h, input logic [6:0] n,
                                input logic [37:0] r);
        check({tag, "_hs_div"}, 64'(hs_div_now), 64'(h));
        check({tag, "_n1"},     64'(n1_now),     64'(n));
        check({tag, "_rfreq"},  64'(rfreq_now),  64'(r));
    endtask

    initial begin
        rst_n = 0; rst_b_n = 0; start = 0; start_b = 0; i2cbusy_b = 0;
        i2crvalid_b = 0; i2crdata_b = 0;
        busy_dly = 2; rsp_dly = 2; drop_idx = -1; stray_en = 0;
        rsp_b = 0; bdone_seen = 0; nb_gaps = 0; gap1 = 0; gap2 = 0; last_done_b = 0;
        nn_sw_b = '1; nn_done_b = '0;
        reset_engine();
        clear_counts();
        load_regs(48'hE0C2BC011EB8);

        // ---- reset state ----
        tick(); tick();
        check("rst_ctrl_a", 64'({busy, done, err, i2cstart, newnow}), 64'd0);
        check("rst_cmd_a", 64'(i2ccmd), 64'd0);
        check("rst_fields_a", 64'({hs_div_now, n1_now, rfreq_now}), 64'd0);
        check("rst_all_b", 64'({busy_b, done_b, err_b, i2cstart_b, newnow_b, i2ccmd_b}), 64'd0);
        rst_n = 1; rst_b_n = 1;
        tick(); tick();

        // ---- 1: normal readback, start latency ----
        clear_counts();
        pulse_start();
        check("t1_busy_after_start", 64'(busy), 64'd1);
        tick();
        check("t1_no_strobe_yet", 64'(i2cstart), 64'd0);
        tick();
        check("t1_strobe_lat3", 64'(i2cstart), 64'd1);
        check("t1_first_cmd_mux", 64'(i2ccmd), 64'(MUXC));
        wait_done(500, "t1");
        check_fields("t1", 3'd7, 7'h03, 38'h02BC011EB8);
        check("t1_newnow", 64'(newnow), 64'h3f);
        check("t1_err", 64'(err), 64'd0);
        check("t1_busy_low_at_done", 64'(busy), 64'd0);
        check("t1_strobes", 64'(nstart_a), 64'd7);
        check("t1_cmd_seq", 64'(cmd_err), 64'd0);

        // ---- 2: timeout on reg A ----
        clear_counts();
        load_regs(48'h614A5AA53CC3);
        drop_idx = 3;
        pulse_start();
        wait_done(1000, "t2");
        check("t2_err", 64'(err), 64'd1);
        check("t2_newnow", 64'(newnow), 64'h07);
        check_fields("t2_unchanged", 3'd7, 7'h03, 38'h02BC011EB8);
        check("t2_strobes", 64'(nstart_a), 64'd5);
        repeat (5) tick();
        check("t2_err_held", 64'(err), 64'd1);
        check("t2_single_done", 64'(done_cnt), 64'd1);

        // ---- 3: back-pressure ----
        clear_counts();
        drop_idx = -1; busy_dly = 40; rsp_dly = 30;
        pulse_start();
        wait_starts(7, 2000, "t3");
        check_fields("t3_no_partial", 3'd7, 7'h03, 38'h02BC011EB8);
        wait_done(1000, "t3");
        check_fields("t3", 3'd3, 7'h05, 38'h0A5AA53CC3);
        check("t3_newnow", 64'(newnow), 64'h3f);
        check("t3_err_cleared", 64'(err), 64'd0);
        check("t3_min_cmd_gap", 64'(min_gap >= 41), 64'd1);
        check("t3_cmd_seq", 64'(cmd_err), 64'd0);

        // ---- 4: start while busy, stray strobe in I2CSW ----
        repeat (45) tick();
        clear_counts();
        busy_dly = 2; rsp_dly = 2; stray_en = 1;
        load_regs(48'h1FFF00123456);
        pulse_start();
        wait_starts(3, 500, "t4");
        pulse_start();
        wait_done(500, "t4");
        check_fields("t4", 3'd0, 7'h7F, 38'h3F00123456);
        repeat (40) tick();
        check("t4_strobes", 64'(nstart_a), 64'd7);
        check("t4_done_count", 64'(done_cnt), 64'd1);
        check("t4_idle", 64'(busy), 64'd0);
        stray_en = 0;

        // ---- 5: reset during RD idx=3 ----
        clear_counts();
        load_regs(48'hE0C2BC011EB8);
        pulse_start();
        wait_starts(5, 500, "t5");
        tick(); tick();
        rst_n = 0;
        #1;
        check("t5_ctrl_zero", 64'({busy, done, err, i2cstart, newnow}), 64'd0);
        check("t5_cmd_zero", 64'(i2ccmd), 64'd0);
        check("t5_fields_zero", 64'({hs_div_now, n1_now, rfreq_now}), 64'd0);
        reset_engine();
        tick(); tick();
        check("t5_held_quiet", 64'({i2cstart, i2ccmd}), 64'd0);
        rst_n = 1;
        tick(); tick();
        clear_counts();
        load_regs(48'hA30780000001);
        pulse_start();
        wait_done(500, "t5");
        check_fields("t5", 3'd5, 7'h0C, 38'h0780000001);
        check("t5_newnow", 64'(newnow), 64'h3f);
        check("t5_strobes", 64'(nstart_a), 64'd7);

        // ---- 6: polling on DUT B ----
        for (int n = 0; n < 8000 && nb_gaps < 2; n++) tick();
        check("t6_two_polls", 64'(nb_gaps >= 2), 64'd1);
        check("t6_gap1", 64'(gap1), 64'd1001);
        check("t6_gap2", 64'(gap2), 64'd1001);
        check("t6_newnow_cleared", 64'(nn_sw_b), 64'd0);
        check("t6_newnow_at_done", 64'(nn_done_b), 64'h3f);
        check("t6_fields", 64'({hs_b, n1_b, rfreq_b}), 64'({3'd0, 7'h44, 38'h1111111111}));
        check("t6_err", 64'(err_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
